// File: rtl/alu_rs_scheduler.sv
// Reservation station and issue scheduler for the shared integer ALU.
// Holds dispatched ALU/branch/jump ops until both operands are resolved
// (snooping the ALU and LSB CDBs). It then issues the lowest-index ready
// entry to a combinational ALU and registers the result onto the ALU CDB.
module alu_rs_scheduler #(
    parameter int RS_SIZE = 8,
    parameter int ROB_W   = 4,
    parameter int OP_W    = 6
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             rdy_in,
    input  logic             clear_in,
    input  logic             ins_valid_in,
    input  logic [OP_W-1:0]  ins_op_in,
    input  logic [31:0]      ins_v1_in,
    input  logic [31:0]      ins_v2_in,
    input  logic             ins_q1_busy_in,
    input  logic             ins_q2_busy_in,
    input  logic [ROB_W-1:0] ins_q1_in,
    input  logic [ROB_W-1:0] ins_q2_in,
    input  logic [31:0]      ins_imm_in,
    input  logic [31:0]      ins_pc_in,
    input  logic [ROB_W-1:0] ins_rob_in,
    output logic             full_out,
    input  logic             lsb_cdb_valid_in,
    input  logic [ROB_W-1:0] lsb_cdb_rob_in,
    input  logic [31:0]      lsb_cdb_val_in,
    output logic             alu_cdb_valid_out,
    output logic [ROB_W-1:0] alu_cdb_rob_out,
    output logic [31:0]      alu_cdb_val_out,
    output logic             alu_cdb_jump_out,
    output logic [31:0]      alu_cdb_target_out
);

    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    // ALU op encoding; 0 (and any unlisted code) produces an all-zero result
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'(4);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SLL   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SRL   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_SRA   = OP_W'(8);
    localparam logic [OP_W-1:0] OP_SLT   = OP_W'(9);
    localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(10);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(11);
    localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(12);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'(13);
    localparam logic [OP_W-1:0] OP_XORI  = OP_W'(14);
    localparam logic [OP_W-1:0] OP_SLLI  = OP_W'(15);
    localparam logic [OP_W-1:0] OP_SRLI  = OP_W'(16);
    localparam logic [OP_W-1:0] OP_SRAI  = OP_W'(17);
    localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(18);
    localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(19);
    localparam logic [OP_W-1:0] OP_LUI   = OP_W'(20);
    localparam logic [OP_W-1:0] OP_AUIPC = OP_W'(21);
    localparam logic [OP_W-1:0] OP_JAL   = OP_W'(22);
    localparam logic [OP_W-1:0] OP_JALR  = OP_W'(23);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(24);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(25);
    localparam logic [OP_W-1:0] OP_BLT   = OP_W'(26);
    localparam logic [OP_W-1:0] OP_BGE   = OP_W'(27);
    localparam logic [OP_W-1:0] OP_BLTU  = OP_W'(28);
    localparam logic [OP_W-1:0] OP_BGEU  = OP_W'(29);

    typedef struct packed {
        logic [31:0] val;
        logic        jump;
        logic [31:0] target;
    } alu_res_t;

    // Station storage: valid bits are control (reset), the rest is payload
    logic [RS_SIZE-1:0] ent_vld;
    logic               ent_b1  [RS_SIZE];
    logic               ent_b2  [RS_SIZE];
    logic [OP_W-1:0]    ent_op  [RS_SIZE];
    logic [31:0]        ent_v1  [RS_SIZE];
    logic [31:0]        ent_v2  [RS_SIZE];
    logic [ROB_W-1:0]   ent_q1  [RS_SIZE];
    logic [ROB_W-1:0]   ent_q2  [RS_SIZE];
    logic [31:0]        ent_imm [RS_SIZE];
    logic [31:0]        ent_pc  [RS_SIZE];
    logic [ROB_W-1:0]   ent_rob [RS_SIZE];

    logic               vld_p0;
    logic [IDX_W-1:0]   iss_idx;
    logic [ROB_W-1:0]   rob_p0;
    alu_res_t           res_p0;
    logic               free_ok;
    logic [IDX_W-1:0]   free_idx;
    logic               ins_ok;
    logic [RS_SIZE-1:0] vld_nxt;

    // Combinational ALU shared by all entries
    function automatic alu_res_t alu_eval(input logic [OP_W-1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] imm,
                                          input logic [31:0] pc);
        alu_res_t           r;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] si;
        logic               take;
        logic               is_br;
        sa     = a;
        sb     = b;
        si     = imm;
        take   = 1'b0;
        is_br  = 1'b0;
        r      = '0;
        case (op)
            OP_ADD:   r.val = a + b;
            OP_SUB:   r.val = a - b;
            OP_AND:   r.val = a & b;
            OP_OR:    r.val = a | b;
            OP_XOR:   r.val = a ^ b;
            OP_SLL:   r.val = a << b[4:0];
            OP_SRL:   r.val = a >> b[4:0];
            OP_SRA:   r.val = sa >>> b[4:0];
            OP_SLT:   r.val = {31'd0, sa < sb};
            OP_SLTU:  r.val = {31'd0, a < b};
            OP_ADDI:  r.val = a + imm;
            OP_ANDI:  r.val = a & imm;
            OP_ORI:   r.val = a | imm;
            OP_XORI:  r.val = a ^ imm;
            OP_SLLI:  r.val = a << imm[4:0];
            OP_SRLI:  r.val = a >> imm[4:0];
            OP_SRAI:  r.val = sa >>> imm[4:0];
            OP_SLTI:  r.val = {31'd0, sa < si};
            OP_SLTIU: r.val = {31'd0, a < imm};
            OP_LUI:   r.val = imm;
            OP_AUIPC: r.val = pc + imm;
            OP_JAL: begin
                r.val    = pc + 32'd4;
                r.jump   = 1'b1;
                r.target = pc + imm;
            end
            OP_JALR: begin
                r.val    = pc + 32'd4;
                r.jump   = 1'b1;
                r.target = (a + imm) & ~32'd1;
            end
            OP_BEQ:  begin is_br = 1'b1; take = (a == b);  end
            OP_BNE:  begin is_br = 1'b1; take = (a != b);  end
            OP_BLT:  begin is_br = 1'b1; take = (sa < sb); end
            OP_BGE:  begin is_br = 1'b1; take = (sa >= sb); end
            OP_BLTU: begin is_br = 1'b1; take = (a < b);   end
            OP_BGEU: begin is_br = 1'b1; take = (a >= b);  end
            default: r = '0;
        endcase
        if (is_br) begin
            r.val    = {31'd0, take};
            r.jump   = take;
            r.target = pc + imm;
        end
        return r;
    endfunction

    // Operand snoop: ALU CDB has priority, then LSB CDB; returns {busy, value}
    function automatic logic [32:0] snoop(input logic busy,
                                          input logic [ROB_W-1:0] tag,
                                          input logic [31:0] val);
        if (busy && alu_cdb_valid_out && tag == alu_cdb_rob_out)
            return {1'b0, alu_cdb_val_out};
        else if (busy && lsb_cdb_valid_in && tag == lsb_cdb_rob_in)
            return {1'b0, lsb_cdb_val_in};
        else
            return {busy, val};
    endfunction

    // Issue stage: pick the lowest-index entry whose operands are both resolved
    always_comb begin
        vld_p0  = 1'b0;
        iss_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ent_vld[i] && !ent_b1[i] && !ent_b2[i]) begin
                vld_p0  = 1'b1;
                iss_idx = IDX_W'(i);
            end
        end
    end

    assign rob_p0 = ent_rob[iss_idx];
    assign res_p0 = alu_eval(ent_op[iss_idx], ent_v1[iss_idx], ent_v2[iss_idx],
                             ent_imm[iss_idx], ent_pc[iss_idx]);

    // Lowest-index free slot from the current state (a slot freed now is not reused now)
    always_comb begin
        free_ok  = 1'b0;
        free_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!ent_vld[i]) begin
                free_ok  = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    assign ins_ok = ins_valid_in && !full_out && free_ok;

    // Occupancy after this edge: issued slot leaves, inserted slot arrives
    always_comb begin
        vld_nxt = ent_vld;
        if (vld_p0)
            vld_nxt[iss_idx] = 1'b0;
        if (ins_ok)
            vld_nxt[free_idx] = 1'b1;
    end

    // Control state and the registered result stage (p0 -> CDB outputs)
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ent_vld            <= '0;
            full_out           <= 1'b0;
            alu_cdb_valid_out  <= 1'b0;
            alu_cdb_rob_out    <= '0;
            alu_cdb_val_out    <= '0;
            alu_cdb_jump_out   <= 1'b0;
            alu_cdb_target_out <= '0;
        end else if (rdy_in) begin
            if (clear_in) begin
                ent_vld           <= '0;
                full_out          <= 1'b0;
                alu_cdb_valid_out <= 1'b0;
            end else begin
                ent_vld           <= vld_nxt;
                full_out          <= &vld_nxt;
                alu_cdb_valid_out <= vld_p0;
                if (vld_p0) begin
                    alu_cdb_rob_out    <= rob_p0;
                    alu_cdb_val_out    <= res_p0.val;
                    alu_cdb_jump_out   <= res_p0.jump;
                    alu_cdb_target_out <= res_p0.target;
                end
            end
        end
    end

    // Entry payload: insert fills the free slot, stored entries snoop the CDBs
    always_ff @(posedge clk_in) begin
        if (rdy_in && !clear_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (ins_ok && free_idx == IDX_W'(i)) begin
                    ent_op[i]                <= ins_op_in;
                    ent_q1[i]                <= ins_q1_in;
                    ent_q2[i]                <= ins_q2_in;
                    ent_imm[i]               <= ins_imm_in;
                    ent_pc[i]                <= ins_pc_in;
                    ent_rob[i]               <= ins_rob_in;
                    {ent_b1[i], ent_v1[i]}   <= snoop(ins_q1_busy_in, ins_q1_in, ins_v1_in);
                    {ent_b2[i], ent_v2[i]}   <= snoop(ins_q2_busy_in, ins_q2_in, ins_v2_in);
                end else if (ent_vld[i]) begin
                    {ent_b1[i], ent_v1[i]}   <= snoop(ent_b1[i], ent_q1[i], ent_v1[i]);
                    {ent_b2[i], ent_v2[i]}   <= snoop(ent_b2[i], ent_q2[i], ent_v2[i]);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Self-checking bench for alu_rs_scheduler: directed scenarios plus random
// traffic, all compared each cycle against a slot-array reference model.
module tb_alu_rs_scheduler;
    localparam int RS_SIZE = 8;
    localparam int ROB_W   = 4;
    localparam int OP_W    = 6;

    localparam logic [5:0] OP_ADD = 6'd1,  OP_SUB = 6'd2,  OP_AND = 6'd3,  OP_OR = 6'd4;
    localparam logic [5:0] OP_XOR = 6'd5,  OP_SLL = 6'd6,  OP_SRL = 6'd7,  OP_SRA = 6'd8;
    localparam logic [5:0] OP_SLT = 6'd9,  OP_SLTU = 6'd10, OP_ADDI = 6'd11, OP_ANDI = 6'd12;
    localparam logic [5:0] OP_ORI = 6'd13, OP_XORI = 6'd14, OP_SLLI = 6'd15, OP_SRLI = 6'd16;
    localparam logic [5:0] OP_SRAI = 6'd17, OP_SLTI = 6'd18, OP_SLTIU = 6'd19, OP_LUI = 6'd20;
    localparam logic [5:0] OP_AUIPC = 6'd21, OP_JAL = 6'd22, OP_JALR = 6'd23, OP_BEQ = 6'd24;
    localparam logic [5:0] OP_BNE = 6'd25, OP_BLT = 6'd26, OP_BGE = 6'd27, OP_BLTU = 6'd28;
    localparam logic [5:0] OP_BGEU = 6'd29;

    logic        clk, rst_n, rdy, clear;
    logic        ins_valid, ins_b1, ins_b2;
    logic [5:0]  ins_op;
    logic [31:0] ins_v1, ins_v2, ins_imm, ins_pc;
    logic [3:0]  ins_q1, ins_q2, ins_rob;
    logic        lsb_valid;
    logic [3:0]  lsb_rob;
    logic [31:0] lsb_val;
    logic        full, cdb_valid, cdb_jump;
    logic [3:0]  cdb_rob;
    logic [31:0] cdb_val, cdb_target;

    alu_rs_scheduler #(.RS_SIZE(RS_SIZE), .ROB_W(ROB_W), .OP_W(OP_W)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .clear_in(clear),
        .ins_valid_in(ins_valid), .ins_op_in(ins_op),
        .ins_v1_in(ins_v1), .ins_v2_in(ins_v2),
        .ins_q1_busy_in(ins_b1), .ins_q2_busy_in(ins_b2),
        .ins_q1_in(ins_q1), .ins_q2_in(ins_q2),
        .ins_imm_in(ins_imm), .ins_pc_in(ins_pc), .ins_rob_in(ins_rob),
        .full_out(full),
        .lsb_cdb_valid_in(lsb_valid), .lsb_cdb_rob_in(lsb_rob), .lsb_cdb_val_in(lsb_val),
        .alu_cdb_valid_out(cdb_valid), .alu_cdb_rob_out(cdb_rob),
        .alu_cdb_val_out(cdb_val), .alu_cdb_jump_out(cdb_jump),
        .alu_cdb_target_out(cdb_target)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks, n_pass, cyc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit          vld;
        logic [5:0]  op;
        logic [31:0] v1, v2, imm, pc;
        bit          b1, b2;
        logic [3:0]  q1, q2, rob;
    } ent_t;

    ent_t        m_rs[RS_SIZE];
    bit          m_cv, m_cjmp, m_full;
    logic [3:0]  m_crob;
    logic [31:0] m_cval, m_ctgt;

    task automatic model_reset();
        for (int i = 0; i < RS_SIZE; i++) m_rs[i].vld = 0;
        m_cv = 0; m_cjmp = 0; m_full = 0; m_crob = 0; m_cval = 0; m_ctgt = 0;
    endtask

    task automatic model_alu(input logic [5:0] op, input logic [31:0] a, b, imm, pc,
                             output logic [31:0] val, output bit jmp, output logic [31:0] tgt);
        bit c;
        val = 0; jmp = 0; tgt = 0; c = 0;
        case (op)
            OP_ADD:   val = a + b;
            OP_SUB:   val = a - b;
            OP_AND:   val = a & b;
            OP_OR:    val = a | b;
            OP_XOR:   val = a ^ b;
            OP_SLL:   val = a << b[4:0];
            OP_SRL:   val = a >> b[4:0];
            OP_SRA:   val = $signed(a) >>> b[4:0];
            OP_SLT:   val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU:  val = (a < b) ? 32'd1 : 32'd0;
            OP_ADDI:  val = a + imm;
            OP_ANDI:  val = a & imm;
            OP_ORI:   val = a | imm;
            OP_XORI:  val = a ^ imm;
            OP_SLLI:  val = a << imm[4:0];
            OP_SRLI:  val = a >> imm[4:0];
            OP_SRAI:  val = $signed(a) >>> imm[4:0];
            OP_SLTI:  val = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
            OP_SLTIU: val = (a < imm) ? 32'd1 : 32'd0;
            OP_LUI:   val = imm;
            OP_AUIPC: val = pc + imm;
            OP_JAL:   begin val = pc + 4; jmp = 1; tgt = pc + imm; end
            OP_JALR:  begin val = pc + 4; jmp = 1; tgt = (a + imm) & 32'hFFFF_FFFE; end
            default:  val = 0;
        endcase
        if (op >= OP_BEQ && op <= OP_BGEU) begin
            case (op)
                OP_BEQ:  c = (a == b);
                OP_BNE:  c = (a != b);
                OP_BLT:  c = ($signed(a) < $signed(b));
                OP_BGE:  c = !($signed(a) < $signed(b));
                OP_BLTU: c = (a < b);
                default: c = !(a < b);
            endcase
            val = c ? 32'd1 : 32'd0; jmp = c; tgt = pc + imm;
        end
    endtask

    function automatic bit cdb_hit(input bit busy, input logic [3:0] q);
        return busy && ((m_cv && q == m_crob) || (lsb_valid && q == lsb_rob));
    endfunction

    function automatic logic [31:0] cdb_value(input logic [3:0] q);
        return (m_cv && q == m_crob) ? m_cval : lsb_val;
    endfunction

    // One clock of the model, using the inputs currently driven
    task automatic model_step();
        int iss, fre, cnt;
        ent_t e, n;
        if (!rdy) return;
        if (clear) begin
            for (int i = 0; i < RS_SIZE; i++) m_rs[i].vld = 0;
            m_cv = 0; m_full = 0;
            return;
        end
        iss = -1; fre = -1;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (iss < 0 && m_rs[i].vld && !m_rs[i].b1 && !m_rs[i].b2) iss = i;
            if (fre < 0 && !m_rs[i].vld) fre = i;
        end
        for (int i = 0; i < RS_SIZE; i++) begin
            e = m_rs[i];
            if (e.vld) begin
                if (cdb_hit(e.b1, e.q1)) begin e.v1 = cdb_value(e.q1); e.b1 = 0; end
                if (cdb_hit(e.b2, e.q2)) begin e.v2 = cdb_value(e.q2); e.b2 = 0; end
                m_rs[i] = e;
            end
        end
        n.vld = 0;
        if (ins_valid && !m_full && fre >= 0) begin
            n.vld = 1; n.op = ins_op; n.imm = ins_imm; n.pc = ins_pc; n.rob = ins_rob;
            n.q1 = ins_q1; n.q2 = ins_q2; n.b1 = ins_b1; n.b2 = ins_b2;
            n.v1 = ins_v1; n.v2 = ins_v2;
            if (cdb_hit(n.b1, n.q1)) begin n.v1 = cdb_value(n.q1); n.b1 = 0; end
            if (cdb_hit(n.b2, n.q2)) begin n.v2 = cdb_value(n.q2); n.b2 = 0; end
        end
        if (iss >= 0) begin
            e = m_rs[iss];
            model_alu(e.op, e.v1, e.v2, e.imm, e.pc, m_cval, m_cjmp, m_ctgt);
            m_crob = e.rob; m_cv = 1;
            m_rs[iss].vld = 0;
        end else begin
            m_cv = 0;
        end
        if (n.vld) m_rs[fre] = n;
        cnt = 0;
        for (int i = 0; i < RS_SIZE; i++) if (m_rs[i].vld) cnt++;
        m_full = (cnt == RS_SIZE);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic check_outputs(input string where);
        check_eq($sformatf("%s_valid@%0d", where, cyc), 32'(cdb_valid), 32'(m_cv));
        check_eq($sformatf("%s_rob@%0d", where, cyc), 32'(cdb_rob), 32'(m_crob));
        check_eq($sformatf("%s_val@%0d", where, cyc), cdb_val, m_cval);
        check_eq($sformatf("%s_jump@%0d", where, cyc), 32'(cdb_jump), 32'(m_cjmp));
        check_eq($sformatf("%s_target@%0d", where, cyc), cdb_target, m_ctgt);
        check_eq($sformatf("%s_full@%0d", where, cyc), 32'(full), 32'(m_full));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs("cyc");
    endtask

    task automatic idle();
        rdy = 1; clear = 0; ins_valid = 0; ins_op = 0; ins_v1 = 0; ins_v2 = 0;
        ins_b1 = 0; ins_b2 = 0; ins_q1 = 0; ins_q2 = 0; ins_imm = 0; ins_pc = 0;
        ins_rob = 0; lsb_valid = 0; lsb_rob = 0; lsb_val = 0;
    endtask

    task automatic set_ins(input logic [5:0] op, input logic [31:0] v1, input bit b1,
                           input logic [3:0] q1, input logic [31:0] v2, input bit b2,
                           input logic [3:0] q2, input logic [31:0] imm,
                           input logic [31:0] pc, input logic [3:0] rob);
        ins_valid = 1; ins_op = op; ins_v1 = v1; ins_b1 = b1; ins_q1 = q1;
        ins_v2 = v2; ins_b2 = b2; ins_q2 = q2; ins_imm = imm; ins_pc = pc; ins_rob = rob;
    endtask

    task automatic lsb(input logic [3:0] rob, input logic [31:0] val);
        lsb_valid = 1; lsb_rob = rob; lsb_val = val;
    endtask

    initial begin
        n_checks = 0; n_pass = 0; cyc = 0;
        idle();
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1;

        // ADD with both operands ready
        set_ins(OP_ADD, 5, 0, 0, 7, 0, 0, 0, 0, 3); tick();
        idle(); tick();
        check_eq("add_valid", 32'(cdb_valid), 1);
        check_eq("add_rob", 32'(cdb_rob), 3);
        check_eq("add_val", cdb_val, 12);
        check_eq("add_jump", 32'(cdb_jump), 0);
        tick();

        // SUB waiting on LSB tag 6
        set_ins(OP_SUB, 0, 1, 6, 1, 0, 0, 0, 0, 2); tick();
        idle(); tick();
        lsb(6, 10); tick();
        idle();
        check_eq("sub_wait", 32'(cdb_valid), 0);
        tick();
        check_eq("sub_valid", 32'(cdb_valid), 1);
        check_eq("sub_val", cdb_val, 9);
        tick();

        // SUB with the LSB broadcast in the insert cycle
        set_ins(OP_SUB, 0, 1, 6, 1, 0, 0, 0, 0, 2); lsb(6, 10); tick();
        idle(); tick();
        check_eq("sub_fast_val", cdb_val, 9);
        check_eq("sub_fast_valid", 32'(cdb_valid), 1);
        tick();

        // Chain through ALU CDB forwarding
        set_ins(OP_ADDI, 1, 0, 0, 0, 0, 0, 2, 0, 1); tick();
        set_ins(OP_ADD, 0, 1, 1, 4, 0, 0, 0, 0, 4); tick();
        check_eq("chain1_rob", 32'(cdb_rob), 1);
        check_eq("chain1_val", cdb_val, 3);
        idle(); tick(); tick();
        check_eq("chain2_rob", 32'(cdb_rob), 4);
        check_eq("chain2_val", cdb_val, 7);
        tick();

        // Fill all entries, drop an extra insert, then drain in index order
        for (int i = 0; i < RS_SIZE; i++) begin
            set_ins(OP_ADD, 0, 1, 9, 32'(i), 0, 0, 0, 0, 4'(i)); tick();
        end
        check_eq("fill_full", 32'(full), 1);
        set_ins(OP_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 15); tick();
        idle(); lsb(9, 100); tick();
        check_eq("fill_still_full", 32'(full), 1);
        idle();
        for (int i = 0; i < RS_SIZE; i++) begin
            tick();
            check_eq($sformatf("drain_rob%0d", i), 32'(cdb_rob), 32'(i));
            check_eq($sformatf("drain_val%0d", i), cdb_val, 32'(100 + i));
            if (i == 0) check_eq("drain_full_fall", 32'(full), 0);
        end
        tick();
        check_eq("drop_extra", 32'(cdb_valid), 0);

        // BEQ taken, then flush with two pending entries
        set_ins(OP_BEQ, 9, 0, 0, 9, 0, 0, 32'h20, 32'h100, 5); tick();
        set_ins(OP_ADD, 0, 1, 12, 1, 0, 0, 0, 0, 10); tick();
        check_eq("beq_jump", 32'(cdb_jump), 1);
        check_eq("beq_target", cdb_target, 32'h120);
        check_eq("beq_val", cdb_val, 1);
        set_ins(OP_ADD, 0, 1, 12, 2, 0, 0, 0, 0, 11); tick();
        set_ins(OP_ADD, 1, 0, 0, 1, 0, 0, 0, 0, 13); clear = 1; tick();
        check_eq("clr_valid", 32'(cdb_valid), 0);
        check_eq("clr_full", 32'(full), 0);
        idle(); lsb(12, 1); tick();
        idle(); repeat (3) tick();
        check_eq("clr_quiet", 32'(cdb_valid), 0);

        // rdy_in low freezes a ready entry and holds the outputs
        set_ins(OP_ADD, 1, 0, 0, 2, 0, 0, 0, 0, 7); tick();
        set_ins(OP_ADD, 3, 0, 0, 4, 0, 0, 0, 0, 8); tick();
        set_ins(OP_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 15); lsb(3, 77); rdy = 0;
        repeat (3) tick();
        check_eq("frz_valid", 32'(cdb_valid), 1);
        check_eq("frz_rob", 32'(cdb_rob), 7);
        idle(); tick();
        check_eq("thaw_rob", 32'(cdb_rob), 8);
        check_eq("thaw_val", cdb_val, 7);
        tick();
        check_eq("thaw_once", 32'(cdb_valid), 0);

        // Asynchronous reset with three entries stored
        for (int i = 0; i < 3; i++) begin
            set_ins(OP_ADD, 0, 1, 13, 1, 0, 0, 0, 0, 4'(i)); tick();
        end
        idle();
        #2 rst_n = 0;
        model_reset();
        #1 check_outputs("arst");
        @(posedge clk);
        #1 check_outputs("arst_hold");
        #2 rst_n = 1;
        lsb(13, 55); tick();
        idle(); repeat (3) tick();
        check_eq("arst_no_bcast", 32'(cdb_valid), 0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] t;
            rdy       = ($urandom_range(0, 9) != 0);
            clear     = ($urandom_range(0, 99) == 0);
            ins_valid = $urandom_range(0, 1);
            ins_op    = 6'($urandom_range(0, 31));
            ins_v1    = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            ins_v2    = ($urandom_range(0, 3) == 0) ? ins_v1 : $urandom;
            ins_b1    = ($urandom_range(0, 2) == 0);
            ins_b2    = ($urandom_range(0, 2) == 0);
            ins_q1    = 4'($urandom_range(0, 15));
            ins_q2    = 4'($urandom_range(0, 15));
            ins_imm   = $urandom;
            ins_pc    = $urandom;
            ins_rob   = 4'($urandom_range(0, 15));
            lsb_valid = ($urandom_range(0, 2) == 0);
            do t = 4'($urandom_range(0, 15)); while (m_cv && t == m_crob);
            lsb_rob   = t;
            lsb_val   = $urandom;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
